// File: rtl/regfile_sequencer.sv
// Regfile access initiator: FETCH -> CAPTURE -> EXECUTE -> WRITEBACK per op.
// Optional EXECUTE watchdog enabled by defining REGSEQ_TIMEOUT_EN.
module regfile_sequencer #(
  parameter int DataSize      = 32,
  parameter int AddrSize      = 5,
  parameter int CountSize     = 16,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AddrSize-1:0]  req_ra_addr,
  input  logic [AddrSize-1:0]  req_rb_addr,
  input  logic [AddrSize-1:0]  req_rt_addr,
  input  logic                 req_do_write,
  output logic                 enable_reg_fetch,
  output logic                 enable_reg_write,
  output logic [AddrSize-1:0]  reg_ra_addr,
  output logic [AddrSize-1:0]  reg_rb_addr,
  output logic [AddrSize-1:0]  reg_rt_addr,
  output logic                 do_reg_write,
  output logic [DataSize-1:0]  write_reg_data,
  input  logic [DataSize-1:0]  reg_ra_data,
  input  logic [DataSize-1:0]  reg_rb_data,
  output logic                 op_valid,
  output logic [DataSize-1:0]  op_a,
  output logic [DataSize-1:0]  op_b,
  input  logic                 res_valid,
  input  logic [DataSize-1:0]  res_data,
  output logic                 done,
  output logic [CountSize-1:0] retire_count,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_EXEC,
    S_WRITE
  } state_t;

  typedef struct packed {
    logic [AddrSize-1:0] ra;
    logic [AddrSize-1:0] rb;
    logic [AddrSize-1:0] rt;
    logic                wr;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic   tmo_hit;

`ifdef REGSEQ_TIMEOUT_EN
  localparam int TmoBits = $clog2(TimeoutCycles + 1);
  localparam int TmoW    = (TmoBits > 8) ? TmoBits : 8;

  logic [TmoW-1:0] tmo_q;

  // res_valid on the limit cycle completes normally
  assign tmo_hit = (state_q == S_EXEC) && !res_valid &&
                   (tmo_q == TmoW'(TimeoutCycles - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (state_q == S_CAPT) begin
      tmo_q <= '0;
    end else if (state_q == S_EXEC && !res_valid) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign err = tmo_hit;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0 && (TimeoutCycles > 0);
`endif

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_CAPT;
      S_CAPT:  state_d = S_EXEC;
      S_EXEC: begin
        if (res_valid) begin
          if (req_q.wr) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      req_q          <= '0;
      op_a           <= '0;
      op_b           <= '0;
      write_reg_data <= '0;
      retire_count   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        req_q.ra <= req_ra_addr;
        req_q.rb <= req_rb_addr;
        req_q.rt <= req_rt_addr;
        req_q.wr <= req_do_write;
      end
      // regfile zeroes its read port when idle, so hold operands here
      if (state_q == S_CAPT) begin
        op_a <= reg_ra_data;
        op_b <= reg_rb_data;
      end
      if (state_q == S_EXEC && res_valid) begin
        write_reg_data <= res_data;
      end
      if (done) begin
        retire_count <= retire_count + 1'b1;
      end
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign enable_reg_fetch = (state_q == S_FETCH);
  assign enable_reg_write = (state_q == S_WRITE);
  assign do_reg_write     = (state_q == S_WRITE) && req_q.wr;
  assign op_valid         = (state_q == S_EXEC);
  assign reg_ra_addr      = req_q.ra;
  assign reg_rb_addr      = req_q.rb;
  assign reg_rt_addr      = req_q.rt;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Random + directed bench for regfile_sequencer with regfile/ALU models.
// Timeout checks are active when REGSEQ_TIMEOUT_EN is defined.
module tb_regfile_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
`ifdef REGSEQ_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_ra_addr;
  logic [AW-1:0] req_rb_addr;
  logic [AW-1:0] req_rt_addr;
  logic          req_do_write;
  logic          enable_reg_fetch;
  logic          enable_reg_write;
  logic [AW-1:0] reg_ra_addr;
  logic [AW-1:0] reg_rb_addr;
  logic [AW-1:0] reg_rt_addr;
  logic          do_reg_write;
  logic [DW-1:0] write_reg_data;
  logic [DW-1:0] reg_ra_data;
  logic [DW-1:0] reg_rb_data;
  logic          op_valid;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          done;
  logic [CW-1:0] retire_count;
  logic          err;

  regfile_sequencer #(
    .DataSize(DW), .AddrSize(AW),
    .CountSize(CW), .TimeoutCycles(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ra_addr(req_ra_addr), .req_rb_addr(req_rb_addr),
    .req_rt_addr(req_rt_addr), .req_do_write(req_do_write),
    .enable_reg_fetch(enable_reg_fetch),
    .enable_reg_write(enable_reg_write),
    .reg_ra_addr(reg_ra_addr), .reg_rb_addr(reg_rb_addr),
    .reg_rt_addr(reg_rt_addr), .do_reg_write(do_reg_write),
    .write_reg_data(write_reg_data),
    .reg_ra_data(reg_ra_data), .reg_rb_data(reg_rb_data),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data),
    .done(done), .retire_count(retire_count), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // regfile environment
  logic [DW-1:0] mem [32];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int            wr_cnt = 0;
  int            ovl_cnt = 0;

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (enable_reg_write && do_reg_write) begin
      mem[reg_rt_addr] <= write_reg_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (enable_reg_fetch && enable_reg_write) ovl_cnt <= ovl_cnt + 1;
    if (enable_reg_fetch) begin
      reg_ra_data <= mem[reg_ra_addr];
      reg_rb_data <= mem[reg_rb_addr];
    end else begin
      reg_ra_data <= '0;
      reg_rb_data <= '0;
    end
  end

  // ALU environment: answers after alu_delay EXECUTE cycles
  int alu_delay = 0;
  bit alu_inc   = 1'b0;
  bit noise_en  = 1'b0;
  int ecnt      = 0;

  always @(negedge clock) begin
    if (op_valid) begin
      if (ecnt == alu_delay) begin
        res_valid <= 1'b1;
        res_data  <= alu_inc ? op_a + 1 : op_a + op_b;
      end else begin
        res_valid <= 1'b0;
        res_data  <= $urandom;
      end
      ecnt <= ecnt + 1;
    end else begin
      ecnt      <= 0;
      res_valid <= noise_en ? 1'($urandom_range(1)) : 1'b0;
      res_data  <= $urandom;
    end
  end

  logic [DW-1:0] model_rf [32];
  int exp_retire = 0;
  int exp_wr     = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clock);
    #1;
  endtask

  task automatic chk_reset_vals;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_fetch", 32'(enable_reg_fetch), 0);
    chk("rst_write", 32'(enable_reg_write), 0);
    chk("rst_dowr", 32'(do_reg_write), 0);
    chk("rst_opv", 32'(op_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_retire", 32'(retire_count), 0);
    chk("rst_opa", op_a, 0);
    chk("rst_opb", op_b, 0);
    chk("rst_wdata", write_reg_data, 0);
    chk("rst_ra", 32'(reg_ra_addr), 0);
    chk("rst_rt", 32'(reg_rt_addr), 0);
  endtask

  task automatic preload(input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    model_rf[a] = d;
    step;
    pre_we = 1'b0;
  endtask

  // Called and returns at a sampling point; fcyc = cycle of FETCH
  task automatic do_op(input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb,
                       input logic [AW-1:0] rt,
                       input bit w, input int d,
                       input bit inc, output int fcyc);
    logic [DW-1:0] ea, eb, er;
    bit tmo;
    int n, nx;
    alu_delay    = d;
    alu_inc      = inc;
    req_ra_addr  = ra;
    req_rb_addr  = rb;
    req_rt_addr  = rt;
    req_do_write = w;
    req_valid    = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      step;
      n++;
    end
    chk("accept_wait", 32'(req_ready), 1);
    ea  = model_rf[ra];
    eb  = model_rf[rb];
    er  = inc ? ea + 1 : ea + eb;
    tmo = TMO_EN && (d >= TMO);
    step;
    fcyc = cyc;
    req_ra_addr  = 5'($urandom);
    req_rb_addr  = 5'($urandom);
    req_rt_addr  = 5'($urandom);
    req_do_write = 1'($urandom_range(1));
    chk("f_fetch", 32'(enable_reg_fetch), 1);
    chk("f_ready", 32'(req_ready), 0);
    chk("f_write", 32'(enable_reg_write), 0);
    chk("f_ra", 32'(reg_ra_addr), 32'(ra));
    chk("f_rb", 32'(reg_rb_addr), 32'(rb));
    chk("f_opv", 32'(op_valid), 0);
    step;
    chk("c_fetch", 32'(enable_reg_fetch), 0);
    chk("c_opv", 32'(op_valid), 0);
    chk("c_ready", 32'(req_ready), 0);
    nx = tmo ? TMO : d + 1;
    for (int i = 0; i < nx; i++) begin
      step;
      chk("x_opv", 32'(op_valid), 1);
      chk("x_opa", op_a, ea);
      chk("x_opb", op_b, eb);
      chk("x_write", 32'(enable_reg_write), 0);
      chk("x_ready", 32'(req_ready), 0);
      if (i == nx - 1) begin
        chk("x_done", 32'(done), 32'(!w && !tmo));
        chk("x_err", 32'(err), 32'(tmo));
      end else begin
        chk("x_done", 32'(done), 0);
        chk("x_err", 32'(err), 0);
      end
    end
    if (w && !tmo) begin
      step;
      chk("w_write", 32'(enable_reg_write), 1);
      chk("w_dowr", 32'(do_reg_write), 1);
      chk("w_fetch", 32'(enable_reg_fetch), 0);
      chk("w_rt", 32'(reg_rt_addr), 32'(rt));
      chk("w_data", write_reg_data, er);
      chk("w_done", 32'(done), 1);
      model_rf[rt] = er;
      exp_wr++;
    end
    if (!tmo) exp_retire = (exp_retire + 1) % (1 << CW);
    step;
    req_valid = 1'b0;
    chk("e_ready", 32'(req_ready), 1);
    chk("e_done", 32'(done), 0);
    chk("e_opv", 32'(op_valid), 0);
    chk("e_retire", 32'(retire_count), 32'(exp_retire));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_ra_addr  = '0;
    req_rb_addr  = '0;
    req_rt_addr  = '0;
    req_do_write = 1'b0;
    step;
    step;
    chk_reset_vals();
    reset = 1'b1;
    step;
    for (int i = 0; i < 32; i++) preload(5'(i), $urandom);
    preload(5'd3, 32'h11);
    preload(5'd4, 32'h22);
    preload(5'd7, 32'h5);

    do_op(5'd3, 5'd4, 5'd5, 1'b1, 0, 1'b0, a0);
    chk("t1_r5", model_rf[5], 32'h33);
    do_op(5'd1, 5'd2, 5'd6, 1'b0, 4, 1'b0, a0);

    do_op(5'd3, 5'd4, 5'd8, 1'b1, 0, 1'b0, a0);
    do_op(5'd8, 5'd3, 5'd9, 1'b1, 0, 1'b0, a1);
    do_op(5'd9, 5'd9, 5'd10, 1'b1, 0, 1'b0, a2);
    chk("b2b_gap1", 32'(a1 - a0), 5);
    chk("b2b_gap2", 32'(a2 - a1), 5);

    do_op(5'd7, 5'd7, 5'd7, 1'b1, 0, 1'b1, a0);
    chk("t4_r7", model_rf[7], 32'h6);

    alu_delay    = 20;
    req_ra_addr  = 5'd1;
    req_rb_addr  = 5'd2;
    req_rt_addr  = 5'd11;
    req_do_write = 1'b1;
    req_valid    = 1'b1;
    step;
    req_valid = 1'b0;
    step;
    step;
    step;
    chk("rx_opv", 32'(op_valid), 1);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    step;
    reset = 1'b1;
    exp_retire = 0;
    step;
    chk("rx_wr", 32'(wr_cnt), 32'(exp_wr));
    do_op(5'd3, 5'd4, 5'd12, 1'b1, 1, 1'b0, a0);

`ifdef REGSEQ_TIMEOUT_EN
    do_op(5'd1, 5'd2, 5'd13, 1'b1, 1000, 1'b0, a0);
    do_op(5'd1, 5'd2, 5'd14, 1'b1, TMO - 1, 1'b0, a0);
`endif

    noise_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      do_op(5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom_range(1)), int'($urandom_range(6)),
            1'($urandom_range(1)), a0);
    end
    noise_en = 1'b0;

    step;
    chk("wr_count", 32'(wr_cnt), 32'(exp_wr));
    chk("overlap", 32'(ovl_cnt), 0);
    for (int i = 0; i < 32; i++) chk("rf_final", mem[i], model_rf[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Drives the register file's fetch/write control port; it is the initiator side of the regfile access protocol.
- Accepts one decoded operation per valid/ready handshake and sequences FETCH -> CAPTURE -> EXECUTE -> WRITEBACK.
- Latches operands, because the regfile clears its read outputs on idle cycles.
- Hands operands to the ALU, waits for the result, then issues the writeback.

Parameters:
DataSize, 32, register/operand width
AddrSize, 5, register address width
CountSize, 16, width of retire counter
TimeoutCycles, 255, EXECUTE watchdog limit (used only with REGSEQ_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  decoded op available
req_ready  out  1  sequencer can accept op
req_ra_addr  in  AddrSize  source A
req_rb_addr  in  AddrSize  source B
req_rt_addr  in  AddrSize  destination
req_do_write  in  1  op writes rt
enable_reg_fetch  out  1  to regfile, fetch phase
enable_reg_write  out  1  to regfile, write phase
reg_ra_addr  out  AddrSize  to regfile
reg_rb_addr  out  AddrSize  to regfile
reg_rt_addr  out  AddrSize  to regfile
do_reg_write  out  1  to regfile, write qualifier
write_reg_data  out  DataSize  to regfile
reg_ra_data  in  DataSize  from regfile (registered, valid cycle after fetch)
reg_rb_data  in  DataSize  from regfile
op_valid  out  1  operands presented to ALU
op_a  out  DataSize  latched operand A
op_b  out  DataSize  latched operand B
res_valid  in  1  ALU result ready
res_data  in  DataSize  ALU result
done  out  1  one-cycle retire pulse
retire_count  out  CountSize  ops retired
err  out  1  timeout abort pulse (0 when feature off)

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except req_ready=1; address/data regs 0; retire_count 0. Reset mid-operation abandons the op and issues no write.
- IDLE: req_ready=1. When req_valid=1 at a clock edge, latch the three addresses and req_do_write, then go to FETCH. req_ready=0 in every other state; a req_valid arriving outside IDLE is held off.
- FETCH (1 cycle): enable_reg_fetch=1; reg_ra_addr/reg_rb_addr driven from latched values.
- CAPTURE (1 cycle): latch reg_ra_data/reg_rb_data into op_a/op_b at the end of the cycle.
- EXECUTE: op_valid=1, op_a/op_b stable. Stay until res_valid=1, then latch res_data into write_reg_data.
  - If the latched do_write=1, go to WRITE.
  - Otherwise pulse done and go to IDLE.
  - res_valid outside EXECUTE is ignored.
- WRITE (1 cycle): enable_reg_write=1, do_reg_write=1, reg_rt_addr=latched rt; done=1; then IDLE.
- Outside FETCH and WRITE, enable_reg_fetch=enable_reg_write=do_reg_write=0. The two enables are never high in the same cycle.
- Latency with zero-cycle ALU (res_valid in first EXECUTE cycle), accept edge = cycle 0:
  - FETCH c1, CAPTURE c2, EXECUTE c3, WRITE/done c4, req_ready=1 again c5.
  - Back-to-back throughput: 1 op per 5 cycles.
- retire_count increments on each done pulse; wraps from 2^CountSize-1 to 0.
- rt equal to ra or rb is legal: the fetch precedes the write, so old values are read.

Optional Feature:
- Macro REGSEQ_TIMEOUT_EN.
- Defined: an 8-bit-min counter clears on entry to EXECUTE and increments each EXECUTE cycle without res_valid. When it reaches TimeoutCycles:
  - pulse err=1 for one cycle;
  - no write, no done, retire_count unchanged;
  - return to IDLE.
  - res_valid in the same cycle as the limit wins (normal completion).
- Undefined: EXECUTE waits indefinitely; err tied to 0.

Test Plan:
- Reset, then preload r3=0x11, r4=0x22; op ra=3 rb=4 rt=5 do_write=1, ALU returns 0x33 immediately -> fetch pulse c1, op_a=0x11/op_b=0x22 at c3, write r5=0x33 at c4, done=1, retire_count=1.
- do_write=0 with ALU delay 4 cycles -> op_valid held 5 cycles, no enable_reg_write, done pulse, retire_count increments.
- req_valid held high for 3 ops -> accepts spaced 5 cycles apart, req_ready low between; retire_count=3.
- rt=ra=7 (r7=0x5), ALU returns op_a+1 -> r7=0x6; operand read was 0x5.
- Assert reset during EXECUTE -> outputs return to reset values, no write observed, next op completes normally.
- REGSEQ_TIMEOUT_EN, TimeoutCycles=4, res_valid never asserted -> err pulse after 4 EXECUTE cycles, no write, retire_count unchanged, req_ready=1 next cycle.
